// File: rtl/security_zone_ctrl.sv
// Alarm-panel controller: OFF/ARMED/ENTRY/ALARM with entry delay, sticky zone record, event count.
// Optional macro INSTANT_ZONE_EN makes unmasked zone 0 an instant (no entry delay) zone.
module security_zone_ctrl #(
   parameter int unsigned NUM_ZONES   = 4,
   parameter int unsigned ENTRY_DELAY = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arm,
   input  logic                 disarm,
   input  logic [NUM_ZONES-1:0] zone_trip,
   input  logic [NUM_ZONES-1:0] zone_mask,
   output logic [1:0]           state,
   output logic                 alarm,
   output logic [NUM_ZONES-1:0] tripped,
   output logic [7:0]           delay_cnt,
   output logic [7:0]           event_cnt
);

   typedef enum logic [1:0] {
      StOff   = 2'd0,
      StArmed = 2'd1,
      StEntry = 2'd2,
      StAlarm = 2'd3
   } state_e;

   localparam logic [7:0] LpDelay = 8'(ENTRY_DELAY);

   state_e               r_state,   w_state_nxt;
   logic [7:0]           r_delay,   w_delay_nxt;
   logic [7:0]           r_event,   w_event_nxt;
   logic [NUM_ZONES-1:0] r_tripped, w_tripped_nxt;
   logic [NUM_ZONES-1:0] w_hit_vec;
   logic                 w_hit;
   logic                 w_instant;

   assign w_hit_vec = zone_trip & ~zone_mask;
   assign w_hit     = |w_hit_vec;

`ifdef INSTANT_ZONE_EN
   assign w_instant = w_hit_vec[0];
`else
   assign w_instant = 1'b0;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_delay_nxt   = 8'd0;
      w_tripped_nxt = r_tripped;
      w_event_nxt   = r_event;
      if (disarm) begin
         w_state_nxt = StOff;
      end else begin
         if (r_state != StOff) begin
            w_tripped_nxt = r_tripped | w_hit_vec;
         end
         unique case (r_state)
            StOff: begin
               if (arm) begin
                  w_state_nxt   = StArmed;
                  w_tripped_nxt = '0;
               end
            end
            StArmed: begin
               if (w_instant) begin
                  w_state_nxt = StAlarm;
               end else if (w_hit) begin
                  w_state_nxt = StEntry;
                  w_delay_nxt = LpDelay;
               end
            end
            StEntry: begin
               // Countdown reaching 1 means this is the last ENTRY cycle.
               if (w_instant || (r_delay == 8'd1)) begin
                  w_state_nxt = StAlarm;
               end else begin
                  w_delay_nxt = r_delay - 8'd1;
               end
            end
            StAlarm: ;
            default: ;
         endcase
         if ((r_state == StArmed) && (w_state_nxt != StArmed) && (r_event != 8'hFF)) begin
            w_event_nxt = r_event + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StOff;
         r_delay   <= 8'd0;
         r_tripped <= '0;
         r_event   <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_delay   <= w_delay_nxt;
         r_tripped <= w_tripped_nxt;
         r_event   <= w_event_nxt;
      end
   end

   assign state     = r_state;
   assign alarm     = (r_state == StAlarm);
   assign tripped   = r_tripped;
   assign delay_cnt = r_delay;
   assign event_cnt = r_event;

endmodule

// File: tb/tb_security_zone_ctrl.sv
// Directed and randomized bench for security_zone_ctrl against a rule-level reference model.
module tb_security_zone_ctrl;

   localparam int NZ = 4;
   localparam int ED = 4;

   logic          clk;
   logic          rst_n;
   logic          arm;
   logic          disarm;
   logic [NZ-1:0] zone_trip;
   logic [NZ-1:0] zone_mask;
   logic [1:0]    state;
   logic          alarm;
   logic [NZ-1:0] tripped;
   logic [7:0]    delay_cnt;
   logic [7:0]    event_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: mode name, cycles spent in ENTRY, trip record, event tally.
   int            m_st;
   int            m_age;
   logic [NZ-1:0] m_trip;
   int            m_evt;

   security_zone_ctrl #(
      .NUM_ZONES  (NZ),
      .ENTRY_DELAY(ED)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .arm      (arm),
      .disarm   (disarm),
      .zone_trip(zone_trip),
      .zone_mask(zone_mask),
      .state    (state),
      .alarm    (alarm),
      .tripped  (tripped),
      .delay_cnt(delay_cnt),
      .event_cnt(event_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st   = 0;
      m_age  = 0;
      m_trip = '0;
      m_evt  = 0;
   endtask

   function automatic bit instant_hit(input logic [NZ-1:0] hv);
`ifdef INSTANT_ZONE_EN
      return hv[0];
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_edge();
      logic [NZ-1:0] hv;
      hv = zone_trip & ~zone_mask;
      if (disarm) begin
         m_st  = 0;
         m_age = 0;
      end else if (m_st == 0) begin
         if (arm) begin
            m_st   = 1;
            m_trip = '0;
         end
      end else begin
         m_trip = m_trip | hv;
         if (m_st == 1) begin
            if (instant_hit(hv) || hv != '0) begin
               m_st  = instant_hit(hv) ? 3 : 2;
               m_age = 0;
               m_evt = (m_evt < 255) ? m_evt + 1 : 255;
            end
         end else if (m_st == 2) begin
            m_age = m_age + 1;
            if (instant_hit(hv) || m_age == ED) m_st = 3;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".state"},     int'(state),     m_st);
      check({tag, ".alarm"},     int'(alarm),     (m_st == 3) ? 1 : 0);
      check({tag, ".tripped"},   int'(tripped),   int'(m_trip));
      check({tag, ".delay_cnt"}, int'(delay_cnt), (m_st == 2) ? ED - m_age : 0);
      check({tag, ".event_cnt"}, int'(event_cnt), m_evt);
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic a, input logic d, input logic [NZ-1:0] t,
                        input logic [NZ-1:0] m);
      arm       = a;
      disarm    = d;
      zone_trip = t;
      zone_mask = m;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, '0, '0);
      model_reset();
      #2;
      check_all("reset");
      check("reset.state_const", int'(state), 0);
      #10 rst_n = 1'b1;

      // Arm and disarm together in OFF stays OFF.
      drive(1'b1, 1'b1, '0, '0);
      tick("arm_disarm_off");
      check("arm_disarm_off.const", int'(state), 0);

      // Basic entry-delay path to ALARM.
      drive(1'b1, 1'b0, '0, '0);
      tick("arm");
      check("arm.const", int'(state), 1);
      drive(1'b0, 1'b0, 4'b0010, '0);
      tick("entry0");
      check("entry0.delay_const", int'(delay_cnt), 4);
      drive(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 3; i++) tick("entry_cnt");
      check("entry_last.delay_const", int'(delay_cnt), 1);
      tick("alarm");
      check("alarm.state_const", int'(state), 3);
      check("alarm.alarm_const", int'(alarm), 1);
      check("alarm.tripped_const", int'(tripped), 4'b0010);
      check("alarm.event_const", int'(event_cnt), 1);

      // ALARM is not self-clearing and ignores arm.
      drive(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 3; i++) tick("alarm_hold");

      // Disarm keeps the record; re-arm clears it.
      drive(1'b0, 1'b1, '0, '0);
      tick("disarm_alarm");
      check("disarm_alarm.tripped_const", int'(tripped), 4'b0010);
      drive(1'b1, 1'b0, '0, '0);
      tick("rearm");
      check("rearm.tripped_const", int'(tripped), 0);

      // A bypassed zone has no effect.
      drive(1'b0, 1'b0, 4'b1000, 4'b1000);
      tick("masked0");
      tick("masked1");
      check("masked.state_const", int'(state), 1);
      check("masked.event_const", int'(event_cnt), 1);

      // Disarm partway through the countdown.
      drive(1'b0, 1'b0, 4'b0100, '0);
      tick("entry_b");
      drive(1'b0, 1'b0, '0, '0);
      tick("entry_b1");
      tick("entry_b2");
      check("entry_b2.delay_const", int'(delay_cnt), 2);
      drive(1'b0, 1'b1, '0, '0);
      tick("disarm_entry");
      check("disarm_entry.tripped_const", int'(tripped), 4'b0100);

      // Zone 0 trip while ARMED.
      drive(1'b1, 1'b0, '0, '0);
      tick("arm_z0");
      drive(1'b0, 1'b0, 4'b0001, '0);
      tick("z0_trip");
`ifdef INSTANT_ZONE_EN
      check("z0_trip.state_const", int'(state), 3);
`else
      check("z0_trip.state_const", int'(state), 2);
      check("z0_trip.delay_const", int'(delay_cnt), 4);
`endif
      check("z0_trip.event_const", int'(event_cnt), 3);

      // Asynchronous reset in the middle of ENTRY.
      drive(1'b0, 1'b1, '0, '0);
      tick("disarm_z0");
      drive(1'b1, 1'b0, '0, '0);
      tick("arm_rst");
      drive(1'b0, 1'b0, 4'b0010, '0);
      tick("entry_rst");
      drive(1'b0, 1'b0, '0, '0);
      tick("entry_rst1");
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      #7 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick("post_rst_off");
      drive(1'b1, 1'b0, '0, '0);
      tick("post_rst_arm");

      // Event counter saturation.
      for (int i = 0; i < 260; i++) begin
         drive(1'b1, 1'b0, '0, '0);
         tick("sat_arm");
         drive(1'b0, 1'b0, 4'b0100, '0);
         tick("sat_trip");
         drive(1'b0, 1'b1, '0, '0);
         tick("sat_disarm");
      end
      check("sat.event_const", int'(event_cnt), 255);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 4) == 0) ? NZ'($urandom) : '0, NZ'($urandom));
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
